// File: rtl/quad_coeff_builder_pkg.sv
// Shared definitions for the root-to-coefficient builder: default width,
// FSM state encoding and result width helpers.
package quad_coeff_builder_pkg;

  localparam int W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_MUL_RR = 2'd1;
  localparam state_t ST_MUL_II = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // b = -(x1r + x2r) needs one bit of growth
  function automatic int b_width(input int w);
    return w + 1;
  endfunction

  // c = rr - ii needs the full product width plus one bit
  function automatic int c_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/quad_coeff_builder_mult.sv
// W-cycle signed shift-add multiplier. Operands must stay stable from the
// start cycle until done. start marks the first accumulation cycle; done is
// high in the last one, and p is valid in that same cycle, so the caller
// captures the product on the edge that ends the run.
module seq_mult_signed
  import quad_coeff_builder_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int CW = $clog2(W);

  logic [W:0]     ma;
  logic [W-1:0]   mb;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  idx;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] part;
  logic [2*W-1:0] sum;
  logic           busy;
  logic           active;
  logic           neg;

  // Multiplicand magnitude keeps the extra bit so -2^(W-1) is exact. The
  // multiplier magnitude fits in W unsigned bits (2^(W-1) at most), which
  // keeps the bit index exactly CW wide.
  assign ma     = a[W-1] ? -{a[W-1], a} : {a[W-1], a};
  assign mb     = b[W-1] ? -b : b;
  assign neg    = a[W-1] ^ b[W-1];
  assign active = start | busy;
  assign idx    = start ? '0 : cnt;
  assign part   = mb[idx] ? ({{(W-1){1'b0}}, ma} << idx) : '0;
  assign sum    = (start ? '0 : acc) + part;
  assign done   = active && (idx == CW'(W - 1));
  assign p      = neg ? -sum : sum;

  // One partial product per cycle; the run ends after bit W-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (active) begin
      acc  <= sum;
      cnt  <= idx + 1'b1;
      busy <= !done;
    end
  end

endmodule

// File: rtl/quad_coeff_builder.sv
// Builds the monic polynomial x^2 + b*x + c from two roots:
// b = -(x1+x2), c = x1*x2. Non-real coefficient sets are flagged with err.
// One shared multiplier computes x1r*x2r then x1i*x2i.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | in_ready high, waiting for a root set
// ST_MUL_RR | multiplier running on x1r*x2r
// ST_MUL_II | multiplier running on x1i*x2i, result loaded at the end
// ST_DONE   | result held until out_ready (error result appears one
//           | cycle after entry)
module quad_coeff_builder
  import quad_coeff_builder_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             x1r,
  input  logic [W-1:0]             x1i,
  input  logic [W-1:0]             x2r,
  input  logic [W-1:0]             x2i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [b_width(W)-1:0]    b,
  output logic [c_width(W)-1:0]    c,
  output logic                     err
);

  state_t         state;
  logic [W-1:0]   x1r_q, x1i_q, x2r_q, x2i_q;
  logic [2*W-1:0] rr;
  logic [2*W-1:0] prod;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_start;
  logic           mul_done;
  logic           accept;
  logic           err_in;
  logic [W:0]     x1i_ext, x2i_neg;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;

  // Compared in W+1 bits so -(-2^(W-1)) does not alias back onto itself.
  assign x1i_ext = {x1i[W-1], x1i};
  assign x2i_neg = -{x2i[W-1], x2i};
  assign err_in  = (x1i_ext != x2i_neg) || ((x2i != '0) && (x1r != x2r));

  // Feed the shared multiplier with the pair for the current phase.
  always_comb begin
    mul_a = x1r_q;
    mul_b = x2r_q;
    if (state == ST_MUL_II) begin
      mul_a = x1i_q;
      mul_b = x2i_q;
    end
  end

  seq_mult_signed #(.W(W)) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .done  (mul_done),
    .p     (prod)
  );

  // Sequencing FSM with input capture and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      x1r_q     <= '0;
      x1i_q     <= '0;
      x2r_q     <= '0;
      x2i_q     <= '0;
      rr        <= '0;
      mul_start <= 1'b0;
      out_valid <= 1'b0;
      b         <= '0;
      c         <= '0;
      err       <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            x1r_q <= x1r;
            x1i_q <= x1i;
            x2r_q <= x2r;
            x2i_q <= x2i;
            if (err_in) begin
              state <= ST_DONE;
            end else begin
              mul_start <= 1'b1;
              state     <= ST_MUL_RR;
            end
          end
        end
        ST_MUL_RR: begin
          if (mul_done) begin
            rr        <= prod;
            mul_start <= 1'b1;
            state     <= ST_MUL_II;
          end
        end
        ST_MUL_II: begin
          if (mul_done) begin
            b         <= -({x1r_q[W-1], x1r_q} + {x2r_q[W-1], x2r_q});
            c         <= {rr[2*W-1], rr} - {prod[2*W-1], prod};
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Only the error path arrives here with out_valid low.
          if (!out_valid) begin
            b         <= '0;
            c         <= '0;
            err       <= 1'b1;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_coeff_builder.sv
// Bench for quad_coeff_builder: table of root sets with expected
// coefficients, a scoreboard queue, plus backpressure and reset-abort runs.
module tb_quad_coeff_builder;

  localparam int W = 8;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    x1r, x1i, x2r, x2i;
  logic            out_valid;
  logic            out_ready;
  logic [W:0]      b;
  logic [2*W:0]    c;
  logic            err;

  typedef struct {
    int x1r;
    int x1i;
    int x2r;
    int x2i;
    int eb;
    int ec;
    int eerr;
    int elat;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  quad_coeff_builder #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1r       (x1r),
    .x1i       (x1i),
    .x2r       (x2r),
    .x2i       (x2i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b         (b),
    .c         (c),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int x1r_v, input int x1i_v, input int x2r_v, input int x2i_v,
                              input int eb, input int ec, input int eerr, input int elat);
    vec_t v;
    v.x1r = x1r_v; v.x1i = x1i_v; v.x2r = x2r_v; v.x2i = x2i_v;
    v.eb = eb; v.ec = ec; v.eerr = eerr; v.elat = elat;
    return v;
  endfunction

  // Reference arithmetic on plain integers.
  function automatic vec_t model(input int x1r_v, input int x1i_v, input int x2r_v, input int x2i_v);
    int e;
    e = ((x1i_v != -x2i_v) || (x2i_v != 0 && x1r_v != x2r_v)) ? 1 : 0;
    if (e != 0)
      return mk(x1r_v, x1i_v, x2r_v, x2i_v, 0, 0, 1, 1);
    return mk(x1r_v, x1i_v, x2r_v, x2i_v, -(x1r_v + x2r_v),
              x1r_v * x2r_v - x1i_v * x2i_v, 0, 2 * W);
  endfunction

  task automatic scramble_inputs();
    x1r = W'($urandom);
    x1i = W'($urandom);
    x2r = W'($urandom);
    x2i = W'($urandom);
  endtask

  task automatic check_result(input string tag, input vec_t e);
    check({tag, " b"},   32'(b),   32'(e.eb) & 32'h1FF);
    check({tag, " c"},   32'(c),   32'(e.ec) & 32'h1FFFF);
    check({tag, " err"}, 32'(err), 32'(e.eerr));
  endtask

  // Drive one root set and wait for its result; hold = cycles of out_ready low.
  task automatic run_vec(input vec_t v, input int hold);
    int   lat;
    int   waited;
    vec_t e;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("in_ready before accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    x1r = W'(v.x1r);
    x1i = W'(v.x1i);
    x2r = W'(v.x2r);
    x2i = W'(v.x2i);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    sb.push_back(v);
    #1;
    check("in_ready after accept", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      check("out_valid timeout", 32'd0, 32'd1);
      sb.delete();
      return;
    end
    check("latency", 32'(lat), 32'(v.elat));
    if (sb.size() == 0) begin
      check("scoreboard empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check_result("result", e);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1;
      scramble_inputs();
      @(posedge clk); #1;
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold in_ready", 32'(in_ready), 32'd0);
      check_result("hold", e);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid after handshake", 32'(out_valid), 32'd0);
    check("in_ready after handshake", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   mode;
    int   r1, i1, r2, i2;

    tbl.push_back(mk(   1,    2,    1,   -2,   -2,      5, 0, 16));
    tbl.push_back(mk(   1,    0,   -4,    0,    3,     -4, 0, 16));
    tbl.push_back(mk(-128, -127, -128,  127,  256,  32513, 0, 16));
    tbl.push_back(mk(-128,    0, -128,    0,  256,  16384, 0, 16));
    tbl.push_back(mk(   1,    2,    3,   -2,    0,      0, 1,  1));
    tbl.push_back(mk( 127,    0,  127,    0, -254,  16129, 0, 16));
    tbl.push_back(mk(-128,    0,  127,    0,    1, -16256, 0, 16));
    tbl.push_back(mk(   5,    3,    5,   -3,  -10,     34, 0, 16));
    tbl.push_back(mk(   0, -128,    0,    0,    0,      0, 1,  1));
    tbl.push_back(mk(   3,    0,    4,    5,    0,      0, 1,  1));
    tbl.push_back(mk(  -7,   -1,   -7,    1,   14,     50, 0, 16));
    tbl.push_back(mk(   0,    0,    0,    0,    0,      0, 0, 16));

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x1r = '0; x1i = '0; x2r = '0; x2i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset b", 32'(b), 32'd0);
    check("reset c", 32'(c), 32'd0);
    check("reset err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      run_vec(tbl[i], 0);

    for (int i = 0; i < 8; i++) begin
      mode = $urandom_range(0, 2);
      r1 = int'($urandom_range(0, 255)) - 128;
      r2 = int'($urandom_range(0, 255)) - 128;
      i1 = int'($urandom_range(0, 255)) - 128;
      i2 = int'($urandom_range(0, 255)) - 128;
      if (mode == 0) begin
        i1 = 0;
        i2 = 0;
      end else if (mode == 1) begin
        r2 = r1;
        i2 = int'($urandom_range(0, 254)) - 127;
        i1 = -i2;
      end
      run_vec(model(r1, i1, r2, i2), 0);
    end

    // backpressure in DONE, then immediate next set
    run_vec(tbl[0], 5);
    run_vec(tbl[1], 0);

    // reset in the middle of the second product
    @(negedge clk);
    x1r = 8'd1; x1i = 8'd2; x2r = 8'd1; x2i = 8'hFE;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(tbl[0]);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("pre-abort out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort b", 32'(b), 32'd0);
    check("abort c", 32'(c), 32'd0);
    check("abort err", 32'(err), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) check("spurious out_valid after abort", 32'(out_valid), 32'd0);
    end
    run_vec(tbl[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
